// File: rtl/multi_user_free_queue.sv
`default_nettype none
// ============================================================================
// Module   : multi_user_free_queue
// Purpose  : Free-pointer pool for the shared-buffer switch. It fills itself
//            with pointers 0..DEPTH-1 after reset, then serves pops (cell
//            allocation) and pushes (pointer return) as a circular FIFO with
//            a show-ahead head.
// Revision : 1.0 - initial release
// ============================================================================
module multi_user_free_queue #(
  parameter int DEPTH = 512,
  parameter int PTR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                ptr_din,
  input  logic                       FQ_wr,
  input  logic                       FQ_rd,
  output logic [PTR_W-1:0]           ptr_dout_s,
  output logic                       ptr_fifo_empty,
  output logic                       FQ_act,
  output logic [$clog2(DEPTH+1)-1:0] FQ_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             act_q, act_d;

  logic [PTR_W-1:0] mem [DEPTH];
  logic             mem_we;
  logic [PTR_W-1:0] mem_wdata;

  logic             pop_ok;
  logic             push_ok;
  logic             unused_din_hi;

  // Upper bits of the returned pointer carry no information for the pool.
  assign unused_din_hi = ^ptr_din[15:PTR_W];

  // Circular index advance; explicit wrap keeps non-power-of-two depths legal.
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = (state_q == ST_RUN) && FQ_rd && (count_q != '0);
  assign push_ok = (state_q == ST_RUN) && FQ_wr && (count_q != CW'(DEPTH));

  // Next-state logic: init fill sequencing, then pop/push bookkeeping.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    act_d     = act_q;
    mem_we    = 1'b0;
    mem_wdata = ptr_din[PTR_W-1:0];
    unique case (state_q)
      ST_INIT: begin
        // The write index doubles as the init counter: slot i receives i.
        mem_we    = 1'b1;
        mem_wdata = PTR_W'(wr_ptr_q);
        wr_ptr_d  = nxt(wr_ptr_q);
        count_d   = count_q + 1'b1;
        if (wr_ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          act_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (push_ok) begin
          mem_we   = 1'b1;
          wr_ptr_d = nxt(wr_ptr_q);
        end
        if (pop_ok) begin
          rd_ptr_d = nxt(rd_ptr_q);
        end
        if (push_ok && !pop_ok) begin
          count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state; reset discards the pool and restarts the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      act_q    <= act_d;
    end
  end

  // Pointer storage; left unreset so it maps onto a RAM, contents rebuilt by init.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= mem_wdata;
    end
  end

  assign ptr_dout_s     = (count_q == '0) ? '0 : mem[rd_ptr_q];
  assign ptr_fifo_empty = (count_q == '0);
  assign FQ_act         = act_q;
  assign FQ_count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_user_free_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_user_free_queue
// Purpose  : Scoreboard bench for the free-pointer queue. A driver issues
//            directed and random pops/pushes and queues the expected per-cycle
//            outputs from a plain queue model; a negedge monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_user_free_queue;

  logic        clk;
  logic        rst;
  logic [15:0] ptr_din;
  logic        FQ_wr;
  logic        FQ_rd;
  logic [9:0]  ptr_dout_s;
  logic        ptr_fifo_empty;
  logic        FQ_act;
  logic [9:0]  FQ_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int   head;
    int   count;
    logic empty;
  } exp_t;

  exp_t exp_q[$];
  int   model[$];

  multi_user_free_queue #(.DEPTH(512), .PTR_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .ptr_din       (ptr_din),
    .FQ_wr         (FQ_wr),
    .FQ_rd         (FQ_rd),
    .ptr_dout_s    (ptr_dout_s),
    .ptr_fifo_empty(ptr_fifo_empty),
    .FQ_act        (FQ_act),
    .FQ_count      (FQ_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the outputs presented during each driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("head", 32'(ptr_dout_s), 32'(e.head));
      chk("count", 32'(FQ_count), 32'(e.count));
      chk("empty", 32'(ptr_fifo_empty), 32'(e.empty));
      chk("act", 32'(FQ_act), 32'd1);
    end
  end

  // One driven cycle: queue the expected outputs, then apply the queue rules.
  task automatic step(input logic rd, input logic wr, input logic [15:0] din);
    exp_t e;
    bit   pop_ok, push_ok;
    FQ_rd   = rd;
    FQ_wr   = wr;
    ptr_din = din;
    e.count = model.size();
    e.empty = (model.size() == 0);
    e.head  = (model.size() == 0) ? 0 : model[0];
    exp_q.push_back(e);
    pop_ok  = rd && (model.size() != 0);
    push_ok = wr && (model.size() != 512);
    if (pop_ok)  void'(model.pop_front());
    if (push_ok) model.push_back(int'(din[9:0]));
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_act"}, 32'(FQ_act), 32'd0);
    chk({tag, "_count"}, 32'(FQ_count), 32'd0);
    chk({tag, "_empty"}, 32'(ptr_fifo_empty), 32'd1);
    chk({tag, "_dout"}, 32'(ptr_dout_s), 32'd0);
  endtask

  // Release reset at a negedge and count edges until FQ_act, with junk on rd/wr.
  task automatic run_init();
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (n < 600) begin
      @(posedge clk);
      #1;
      n++;
      if (FQ_act) break;
      FQ_rd   = 1'($urandom_range(0, 1));
      FQ_wr   = 1'($urandom_range(0, 1));
      ptr_din = 16'($urandom);
    end
    chk("init_edges", 32'(n), 32'd512);
    FQ_rd = 1'b0;
    FQ_wr = 1'b0;
    model.delete();
    for (int i = 0; i < 512; i++) model.push_back(i);
    chk("init_count", 32'(FQ_count), 32'd512);
    chk("init_dout", 32'(ptr_dout_s), 32'd0);
    chk("init_empty", 32'(ptr_fifo_empty), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    FQ_rd   = 1'b0;
    FQ_wr   = 1'b0;
    ptr_din = 16'h0;
    #1;
    check_reset_outputs("rst0");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");

    run_init();

    // Drain the freshly built pool in order.
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    // Underflow attempts, then a push with junk upper bits.
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'hA955);
    step(1'b0, 1'b0, 16'h0);
    // Simultaneous pop/push on an empty queue.
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'hFC3A);
    step(1'b0, 1'b0, 16'h0);

    // Fill to capacity, then overflow attempts and a pop+push at full.
    while (model.size() < 512) step(1'b0, 1'b1, 16'($urandom));
    repeat (3) step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h0077);
    step(1'b0, 1'b0, 16'h0);

    // Pop+push at count 300, then drain so the tail entry is observed.
    while (model.size() > 300) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h0123);
    while (model.size() > 0) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 55), 16'($urandom));
    end

    // Bring count to 100 and reset mid-cycle.
    while (model.size() > 100) step(1'b1, 1'b0, 16'h0);
    while (model.size() < 100) step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, 16'h0);
    FQ_rd = 1'b0;
    FQ_wr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model.delete();
    repeat (2) @(posedge clk);

    run_init();
    for (int i = 0; i < 512; i++) step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
